beta_lsu_ctrl: RTL and testbench

Load/store unit controller sitting between the execute stage and the data memory port. It consumes the memory fields of the decoded control word (`exe_mem_op_en`, `exe_mem_op`, `exe_mem_op_size`, `dec_not_sign_ext`), the ALU-computed address and the rs2 store data. It sequences a single-outstanding request/grant/response transaction on the data bus and stalls the pipeline while the access is in flight. It returns aligned, extended load data, or an exception, to writeback, so that memory latency is no longer fixed at one cycle.

---
 rtl/beta_lsu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_beta_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_lsu_ctrl.sv
// beta_lsu_ctrl: single-outstanding load/store controller between execute and the data bus.
// Optional feature macro BETA_LSU_MISALIGN_EXC_EN traps misaligned half/word accesses.
package beta_pkg;
    localparam logic       MEM_LOAD_OP    = 1'b0;
    localparam logic       MEM_STORE_OP   = 1'b1;
    localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF  = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD  = 2'b10;
endpackage

module beta_lsu_ctrl
    import beta_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mem_op_en_i,
    input  logic        mem_op_i,
    input  logic [1:0]  mem_op_size_i,
    input  logic        not_sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_wb_en_o,
    output logic [31:0] lsu_rdata_o,
    output logic [4:0]  lsu_rd_addr_o,
    output logic        lsu_exc_o,
    output logic [1:0]  lsu_exc_cause_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        nse_q, nse_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wb_q, wb_d;
    logic        exc_q, exc_d;
    logic [1:0]  cause_q, cause_d;

    logic        accept;
    logic [1:0]  in_off;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        in_misalign;
    logic [31:0] ld_shifted;
    logic [31:0] ld_ext;

    assign accept = mem_op_en_i & ((state_q == StIdle) | (state_q == StDone));

    // Lane offset is truncated to the access size, so misaligned halves/words land aligned.
    always_comb begin
        in_off      = 2'b00;
        in_be       = 4'b1111;
        in_wdata    = wdata_i;
        in_misalign = 1'b0;
        case (mem_op_size_i)
            MEM_SIZE_BYTE: begin
                in_off   = addr_i[1:0];
                in_be    = 4'b0001 << addr_i[1:0];
                in_wdata = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                in_off   = {addr_i[1], 1'b0};
                in_be    = 4'b0011 << {addr_i[1], 1'b0};
                in_wdata = {2{wdata_i[15:0]}};
`ifdef BETA_LSU_MISALIGN_EXC_EN
                in_misalign = addr_i[0];
`endif
            end
            default: begin
`ifdef BETA_LSU_MISALIGN_EXC_EN
                in_misalign = |addr_i[1:0];
`endif
            end
        endcase
    end

    always_comb begin
        ld_shifted = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            MEM_SIZE_BYTE: ld_ext = {{24{~nse_q & ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_SIZE_HALF: ld_ext = {{16{~nse_q & ld_shifted[15]}}, ld_shifted[15:0]};
            default:       ld_ext = ld_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        nse_d   = nse_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        wb_d    = wb_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (mem_op_en_i) begin
                    store_d = (mem_op_i == MEM_STORE_OP);
                    size_d  = mem_op_size_i;
                    nse_d   = not_sign_ext_i;
                    off_d   = in_off;
                    addr_d  = addr_i[31:2];
                    be_d    = in_be;
                    wdata_d = in_wdata;
                    rd_d    = rd_addr_i;
                    if (in_misalign) begin
                        state_d = StDone;
                        wb_d    = 1'b0;
                        exc_d   = 1'b1;
                        cause_d = {1'b0, mem_op_i == MEM_STORE_OP};
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (data_gnt_i) begin
                    state_d = StResp;
                end
            end
            default: begin
                if (data_rvalid_i) begin
                    state_d = StDone;
                    exc_d   = data_err_i;
                    cause_d = {1'b1, store_q};
                    wb_d    = ~store_q & ~data_err_i;
                    if (~store_q & ~data_err_i) begin
                        rdata_d = ld_ext;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            nse_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            wb_q    <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            nse_q   <= nse_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            wb_q    <= wb_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    assign data_req_o      = (state_q == StReq);
    assign data_we_o       = store_q;
    assign data_be_o       = be_q;
    assign data_addr_o     = {addr_q, 2'b00};
    assign data_wdata_o    = wdata_q;
    assign lsu_busy_o      = (state_q == StReq) | (state_q == StResp) | accept;
    assign lsu_done_o      = (state_q == StDone);
    assign lsu_wb_en_o     = lsu_done_o & wb_q;
    assign lsu_rdata_o     = rdata_q;
    assign lsu_rd_addr_o   = rd_q;
    assign lsu_exc_o       = lsu_done_o & exc_q;
    assign lsu_exc_cause_o = lsu_exc_o ? cause_q : 2'b00;

endmodule

// File: tb/tb_beta_lsu_ctrl.sv
// Testbench for beta_lsu_ctrl: directed vector table, hand sequences, randomized accesses vs model.
module tb_beta_lsu_ctrl;
    import beta_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_op_en = 1'b0;
    logic        mem_op = 1'b0;
    logic [1:0]  mem_op_size = 2'b00;
    logic        not_sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd_addr = '0;
    logic        data_req;
    logic        data_gnt = 1'b0;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        data_err = 1'b0;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_wb_en;
    logic [31:0] lsu_rdata;
    logic [4:0]  lsu_rd_addr;
    logic        lsu_exc;
    logic [1:0]  lsu_exc_cause;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    beta_lsu_ctrl dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .mem_op_en_i    (mem_op_en),
        .mem_op_i       (mem_op),
        .mem_op_size_i  (mem_op_size),
        .not_sign_ext_i (not_sign_ext),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rd_addr_i      (rd_addr),
        .data_req_o     (data_req),
        .data_gnt_i     (data_gnt),
        .data_we_o      (data_we),
        .data_be_o      (data_be),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata),
        .data_err_i     (data_err),
        .lsu_busy_o     (lsu_busy),
        .lsu_done_o     (lsu_done),
        .lsu_wb_en_o    (lsu_wb_en),
        .lsu_rdata_o    (lsu_rdata),
        .lsu_rd_addr_o  (lsu_rd_addr),
        .lsu_exc_o      (lsu_exc),
        .lsu_exc_cause_o(lsu_exc_cause)
    );

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        nse;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        logic        err;
        int          gd;
        int          rdl;
        logic [4:0]  rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic        exc;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: per-lane byte arithmetic straight from the access rules.
    task automatic model(inout vec_t v);
        int nb;
        int off;
        int lo;
        nb  = (v.sz == MEM_SIZE_BYTE) ? 1 : (v.sz == MEM_SIZE_HALF) ? 2 : 4;
        lo  = int'(v.a[1:0]);
        off = (lo / nb) * nb;
`ifdef BETA_LSU_MISALIGN_EXC_EN
        v.mis = (lo % nb) != 0;
`else
        v.mis = 1'b0;
`endif
        v.be = '0;
        v.ewd = '0;
        v.erd = '0;
        for (int i = 0; i < 4; i++) begin
            v.be[i] = (i >= off) && (i < off + nb);
            v.ewd[8*i +: 8] = v.wd[8*(i % nb) +: 8];
        end
        for (int i = 0; i < nb; i++) v.erd[8*i +: 8] = v.rdat[8*(off + i) +: 8];
        if (!v.nse && nb < 4 && v.erd[8*nb-1])
            for (int i = 8 * nb; i < 32; i++) v.erd[i] = 1'b1;
        if (v.mis) begin
            v.exc = 1'b1;
            v.cause = {1'b0, v.st};
        end else if (v.err) begin
            v.exc = 1'b1;
            v.cause = {1'b1, v.st};
        end else begin
            v.exc = 1'b0;
            v.cause = 2'b00;
        end
    endtask

    // Starts at a negedge in IDLE or DONE; returns at the negedge of the resulting DONE cycle.
    task automatic access(input vec_t v);
        logic ewb;
        ewb = ~v.st & ~v.exc;
        mem_op_en = 1'b1;
        mem_op = v.st;
        mem_op_size = v.sz;
        not_sign_ext = v.nse;
        addr = v.a;
        wdata = v.wd;
        rd_addr = v.rd;
        #1;
        check("busy_accept", 32'(lsu_busy), 32'd1);
        @(negedge clk);
        mem_op_en = 1'b0;
        addr = $urandom;
        wdata = $urandom;
        if (!v.mis) begin
            for (int k = 0; k <= v.gd; k++) begin
                check("req_held", 32'(data_req), 32'd1);
                check("addr", data_addr, {v.a[31:2], 2'b00});
                check("we", 32'(data_we), 32'(v.st));
                check("be", 32'(data_be), 32'(v.be));
                check("wdata", data_wdata, v.ewd);
                check("busy_req", 32'(lsu_busy), 32'd1);
                check("done_early", 32'(lsu_done), 32'd0);
                data_gnt = (k == v.gd);
                data_rvalid = 1'($urandom_range(0, 1));
                data_rdata = $urandom;
                @(negedge clk);
            end
            data_gnt = 1'b0;
            for (int k = 0; k <= v.rdl; k++) begin
                check("req_dropped", 32'(data_req), 32'd0);
                check("busy_resp", 32'(lsu_busy), 32'd1);
                check("done_early", 32'(lsu_done), 32'd0);
                data_rvalid = (k == v.rdl);
                data_rdata = (k == v.rdl) ? v.rdat : $urandom;
                data_err = (k == v.rdl) ? v.err : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            data_rvalid = 1'b0;
            data_err = 1'b0;
        end else begin
            check("mis_no_req", 32'(data_req), 32'd0);
        end
        check("done", 32'(lsu_done), 32'd1);
        check("busy_done", 32'(lsu_busy), 32'd0);
        check("exc", 32'(lsu_exc), 32'(v.exc));
        check("cause", 32'(lsu_exc_cause), 32'(v.cause));
        check("wb_en", 32'(lsu_wb_en), 32'(ewb));
        check("rd_addr", 32'(lsu_rd_addr), 32'(v.rd));
        if (ewb) check("rdata", lsu_rdata, v.erd);
    endtask

    task automatic add(input logic st, input logic [1:0] sz, input logic nse, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat, input logic err,
                       input int gd, input int rdl, input logic mis, input logic [3:0] be,
                       input logic [31:0] ewd, input logic [31:0] erd, input logic exc,
                       input logic [1:0] cause);
        vec_t v;
        v.st = st; v.sz = sz; v.nse = nse; v.a = a; v.wd = wd; v.rdat = rdat; v.err = err;
        v.gd = gd; v.rdl = rdl; v.rd = 5'(vecs.size() + 1); v.mis = mis; v.be = be;
        v.ewd = ewd; v.erd = erd; v.exc = exc; v.cause = cause;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t rv;
        // Hand-computed vectors, applied back-to-back (each accepted in the previous DONE).
        add(1'b0, MEM_SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0,
            1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 2'b00);
        add(1'b0, MEM_SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80000000, 1'b0, 0, 0,
            1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 2'b00);
        add(1'b0, MEM_SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80000000, 1'b0, 0, 1,
            1'b0, 4'b1000, 32'h0, 32'h00000080, 1'b0, 2'b00);
        add(1'b1, MEM_SIZE_HALF, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1'b0, 0, 0,
            1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 2'b00);
        add(1'b1, MEM_SIZE_WORD, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0, 4, 0,
            1'b0, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 2'b00);
`ifdef BETA_LSU_MISALIGN_EXC_EN
        add(1'b0, MEM_SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'h11228899, 1'b0, 0, 0,
            1'b1, 4'b0011, 32'h0, 32'h0, 1'b1, 2'b00);
        add(1'b1, MEM_SIZE_WORD, 1'b0, 32'h603, 32'h01020304, 32'h0, 1'b0, 0, 0,
            1'b1, 4'b1111, 32'h01020304, 32'h0, 1'b1, 2'b01);
`else
        add(1'b0, MEM_SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'h11228899, 1'b0, 0, 0,
            1'b0, 4'b0011, 32'h0, 32'hFFFF8899, 1'b0, 2'b00);
        add(1'b1, MEM_SIZE_WORD, 1'b0, 32'h603, 32'h01020304, 32'h0, 1'b0, 0, 0,
            1'b0, 4'b1111, 32'h01020304, 32'h0, 1'b0, 2'b00);
`endif
        add(1'b0, MEM_SIZE_WORD, 1'b0, 32'h400, 32'h0, 32'h55555555, 1'b1, 1, 2,
            1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 2'b10);
        add(1'b1, MEM_SIZE_BYTE, 1'b0, 32'h401, 32'h0000005A, 32'h0, 1'b0, 0, 0,
            1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, 2'b00);
        add(1'b0, MEM_SIZE_HALF, 1'b1, 32'h402, 32'h0, 32'hBEEF1234, 1'b0, 2, 0,
            1'b0, 4'b1100, 32'h0, 32'h0000BEEF, 1'b0, 2'b00);
        add(1'b1, MEM_SIZE_WORD, 1'b0, 32'h500, 32'h0BADF00D, 32'h0, 1'b1, 0, 3,
            1'b0, 4'b1111, 32'h0BADF00D, 32'h0, 1'b1, 2'b11);
        add(1'b0, MEM_SIZE_BYTE, 1'b0, 32'h001, 32'h0, 32'h00007F00, 1'b0, 0, 0,
            1'b0, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 2'b00);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_all_zero", 32'(|{data_req, data_we, data_be, data_addr, data_wdata, lsu_busy,
              lsu_done, lsu_wb_en, lsu_rdata, lsu_rd_addr, lsu_exc, lsu_exc_cause}), 32'd0);
        rstn = 1'b1;
        #1;
        check("idle_busy", 32'(lsu_busy), 32'd0);
        @(negedge clk);

        foreach (vecs[i]) access(vecs[i]);
        @(negedge clk);
        check("idle_after_done", 32'(lsu_done), 32'd0);

        // Reset during RESP abandons the access; a late rvalid must not complete anything.
        mem_op_en = 1'b1; mem_op = MEM_LOAD_OP; mem_op_size = MEM_SIZE_WORD; addr = 32'h7000;
        @(negedge clk);
        mem_op_en = 1'b0; data_gnt = 1'b1;
        @(negedge clk);
        data_gnt = 1'b0;
        check("resp_busy", 32'(lsu_busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_all_zero", 32'(|{data_req, data_we, data_be, data_addr, data_wdata,
              lsu_busy, lsu_done, lsu_wb_en, lsu_rdata, lsu_rd_addr, lsu_exc, lsu_exc_cause}),
              32'd0);
        rstn = 1'b1;
        data_rvalid = 1'b1; data_rdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_rvalid_done", 32'(lsu_done), 32'd0);
            check("late_rvalid_busy", 32'(lsu_busy), 32'd0);
        end
        data_rvalid = 1'b0;

        // Randomized accesses, sometimes back-to-back, sometimes with idle gaps.
        for (int n = 0; n < 300; n++) begin
            rv.st = 1'($urandom_range(0, 1));
            rv.sz = 2'($urandom_range(0, 3));
            rv.nse = 1'($urandom_range(0, 1));
            rv.a = $urandom;
            rv.wd = $urandom;
            rv.rdat = $urandom;
            rv.err = ($urandom_range(0, 7) == 0);
            rv.gd = $urandom_range(0, 3);
            rv.rdl = $urandom_range(0, 3);
            rv.rd = 5'($urandom);
            model(rv);
            access(rv);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
